consmax_ctrl: RTL
=================

# consmax_ctrl

Sequencing controller for the ConSmax datapath. It programs the two INT-to-FP LUTs from a host word stream and gates input traffic while the LUTs are written. It issues input words to the datapath under a credit scheme and buffers results in an output FIFO, which gives the non-stallable datapath a valid/ready output with row framing (`m_last`). It sits between the attention-score producer and the ConSmax instance.

## Interface
- `IDATA_BIT`, 8, input integer width.
- `ODATA_BIT`, 8, output integer width.
- `CDATA_BIT`, 8, shift config width.
- `LUT_DATA`, 16, LUT word width (FP, 1+8+7).
- `LUT_ADDR`, 4, per-LUT address width; each LUT has `2**LUT_ADDR` entries.
- `LEN_BIT`, 8, row-length width.
- `FIFO_DEPTH`, 8, output FIFO depth; must be a power of 2 and ≥5.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset.
- `cfg_shift` in CDATA_BIT: output scale shift; sampled on load-request acceptance.
- `cfg_row_len` in LEN_BIT: elements per row; sampled with `cfg_shift`; a value of 0 is treated as 1.
- `lut_load_req` in 1: pulse that requests a LUT (re)load.
- `lut_in_valid`, `lut_in_ready` in/out 1: LUT word handshake.
- `lut_in_data` in LUT_DATA: LUT word.
- `lut_loaded` out 1: LUTs hold a complete table.
- `busy` out 1: high in DRAIN or LOAD.
- `s_valid`, `s_ready` in/out 1: input handshake.
- `s_data` in IDATA_BIT: input word.
- `cm_idata` out IDATA_BIT: to datapath `idata`.
- `cm_idata_valid` out 1: to datapath `idata_valid`.
- `cm_shift` out CDATA_BIT: to `cfg_consmax_shift`.
- `cm_lut_waddr` out LUT_ADDR+1: to `lut_waddr`.
- `cm_lut_wen` out 1: to `lut_wen`.
- `cm_lut_wdata` out LUT_DATA: to `lut_wdata`.
- `cm_odata` in ODATA_BIT: from datapath `odata`.
- `cm_odata_valid` in 1: from datapath `odata_valid`.
- `m_valid`, `m_ready` out/in 1: output handshake.
- `m_data` out ODATA_BIT: output word.
- `m_last` out 1: last element of a row.

## Operation
- FSM states: IDLE, DRAIN, LOAD, RUN. Reset enters IDLE.
- IDLE or RUN, on `lut_load_req`:
  - Latch `cfg_shift` into `cm_shift` and `cfg_row_len` into `row_len`.
  - Clear `lut_loaded`.
  - Go to DRAIN.
- `lut_load_req` is ignored in DRAIN and LOAD.
- DRAIN: `s_ready`=0. Wait until `occ`==0, i.e. every issued word has been popped from the FIFO. Then go to LOAD and clear `wcnt` and both row counters.
- LOAD:
  - `lut_in_ready`=1.
  - Each accepted word registers `cm_lut_wen`=1, `cm_lut_waddr`=`wcnt`, `cm_lut_wdata`=data for exactly one cycle, then increments `wcnt` (LUT_ADDR+1 bits).
  - Addresses `0..2**LUT_ADDR-1` go to LUT0 (low nibble); the upper half goes to LUT1 (high nibble).
  - Acceptance of word `2**(LUT_ADDR+1)-1` sets `lut_loaded`=1 and moves the FSM to RUN.
- RUN:
  - `s_ready` = (`occ` < FIFO_DEPTH) OR (`m_valid` AND `m_ready`).
  - On accept, register `cm_idata`=`s_data` and `cm_idata_valid`=1 for one cycle.
- `occ` counts words accepted but not yet popped. It increments on accept and decrements on pop; simultaneous accept and pop leave it unchanged. `occ` ≤ FIFO_DEPTH, which guarantees that no `cm_odata_valid` beat is ever dropped.
- Output FIFO: pushes `cm_odata` on `cm_odata_valid`. `m_valid` = FIFO not empty; `m_data` = head entry.
- Row framing: `ocnt` counts pops. `m_last` = `m_valid` AND (`ocnt` == `row_len`-1). On a pop with `m_last`, `ocnt` wraps to 0.
- `cm_lut_wen` and `cm_idata_valid` are never high in the same cycle, and never within the same datapath pipeline window.

## Timing
- Reset values:
  - FSM = IDLE.
  - All `cm_*` outputs = 0.
  - `s_ready`, `lut_in_ready`, `lut_loaded`, `busy`, `m_valid`, `m_last` = 0.
  - `occ`, `wcnt`, `ocnt` = 0; FIFO pointers = 0.
  - `m_data` = 0.
- Reset asserted mid-LOAD or mid-RUN aborts the operation immediately. In-flight datapath results arriving after reset are discarded by the FIFO, which is held empty while `rstn`=0. After reset a reload is required.
- Datapath latency: `cm_idata_valid` to `cm_odata_valid` is 3 cycles.
- Input accept at edge E0 gives `m_valid` high after edge E4: 4-cycle latency.
- With `m_ready`=1 and FIFO_DEPTH≥5, throughput is 1 word/cycle.
- `m_ready`=0 stalls `s_ready` once `occ`=FIFO_DEPTH.
- The LOAD-to-RUN transition happens on the same edge that accepts the final LUT word. Its `cm_lut_wen` pulse occupies the following cycle. The first `cm_idata_valid` is at the earliest one cycle after that.
- DRAIN lasts 1 cycle when `occ`=0 at entry. Otherwise DRAIN ends on the edge after the final pop.

## Test plan
- Reset, then load 32 words with values `0x3F80+i`.
  - `cm_lut_waddr` sequences 0..31 with one `cm_lut_wen` pulse per word.
  - `lut_loaded` rises with the 32nd word.
  - `s_ready` stays 0 before that point.
- Load, then stream 16 words with `m_ready`=1 and `cfg_row_len`=4.
  - First `m_valid` appears 4 cycles after the first accept.
  - 16 consecutive outputs are produced in datapath order.
  - `m_last` is high on outputs 3, 7, 11 and 15.
- Stream 20 words with `m_ready`=0 and FIFO_DEPTH=8.
  - Exactly 8 words are accepted, then `s_ready`=0.
  - Releasing `m_ready` drains all 8 words in order, with no loss.
- Assert `lut_load_req` mid-row with 5 words outstanding and `m_ready` toggling.
  - `busy`=1 and `s_ready`=0.
  - All 5 words are popped before the first `cm_lut_wen`.
  - `ocnt` is reset and the new `cm_shift` is applied.
- `lut_load_req` during LOAD and `cfg_row_len`=0.
  - The repeated request is ignored.
  - With row length 0, every output carries `m_last`=1.
- Reset asserted mid-LOAD (word 10) and mid-RUN.
  - All outputs return to their reset values.
  - Late `cm_odata_valid` beats are not forwarded.
  - A full reload is required before `s_ready` returns to 1.

Source files
------------

// File: rtl/consmax_ctrl.sv
// rtl/consmax_ctrl.sv - ConSmax sequencing controller
// LUT programming, credit-gated input issue and a row-framed output FIFO for the datapath.
module consmax_ctrl #(
  parameter int IDATA_BIT  = 8,
  parameter int ODATA_BIT  = 8,
  parameter int CDATA_BIT  = 8,
  parameter int LUT_DATA   = 16,
  parameter int LUT_ADDR   = 4,
  parameter int LEN_BIT    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CDATA_BIT-1:0] cfg_shift,
  input  logic [LEN_BIT-1:0]   cfg_row_len,
  input  logic                 lut_load_req,
  input  logic                 lut_in_valid,
  output logic                 lut_in_ready,
  input  logic [LUT_DATA-1:0]  lut_in_data,
  output logic                 lut_loaded,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IDATA_BIT-1:0] s_data,
  output logic [IDATA_BIT-1:0] cm_idata,
  output logic                 cm_idata_valid,
  output logic [CDATA_BIT-1:0] cm_shift,
  output logic [LUT_ADDR:0]    cm_lut_waddr,
  output logic                 cm_lut_wen,
  output logic [LUT_DATA-1:0]  cm_lut_wdata,
  input  logic [ODATA_BIT-1:0] cm_odata,
  input  logic                 cm_odata_valid,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ODATA_BIT-1:0] m_data,
  output logic                 m_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [LEN_BIT-1:0] LEN_ONE = LEN_BIT'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RUN} state_t;

  state_t               state_q, state_d;
  logic [CDATA_BIT-1:0] shift_q, shift_d;
  logic [LEN_BIT-1:0]   row_len_q, row_len_d;
  logic                 lut_loaded_q, lut_loaded_d;
  logic [LUT_ADDR:0]    wcnt_q, wcnt_d;
  logic                 lut_wen_q, lut_wen_d;
  logic [LUT_ADDR:0]    lut_waddr_q, lut_waddr_d;
  logic [LUT_DATA-1:0]  lut_wdata_q, lut_wdata_d;
  logic [IDATA_BIT-1:0] idata_q, idata_d;
  logic                 idata_valid_q, idata_valid_d;
  logic [PW:0]          occ_q, occ_d;
  logic [LEN_BIT-1:0]   ocnt_q, ocnt_d;
  logic [PW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ODATA_BIT-1:0] mem_q [FIFO_DEPTH];

  logic [PW:0] fifo_cnt;
  logic        push, pop, accept, lut_acc;

  assign fifo_cnt = wr_ptr_q - rd_ptr_q;
  // Only beats owed to an outstanding credit are stored, so results that were
  // in flight across a reset never reach the FIFO.
  assign push     = cm_odata_valid && (occ_q > fifo_cnt);
  assign m_valid  = (wr_ptr_q != rd_ptr_q);
  assign m_data   = m_valid ? mem_q[rd_ptr_q[PW-1:0]] : '0;
  assign m_last   = m_valid && (ocnt_q == row_len_q - LEN_ONE);
  assign pop      = m_valid && m_ready;
  assign s_ready  = (state_q == RUN) && ((occ_q < DEPTH_C) || pop);
  assign accept   = s_valid && s_ready;
  assign lut_in_ready = (state_q == LOAD);
  assign lut_acc  = lut_in_valid && lut_in_ready;
  assign busy     = (state_q == DRAIN) || (state_q == LOAD);

  assign lut_loaded     = lut_loaded_q;
  assign cm_shift       = shift_q;
  assign cm_lut_wen     = lut_wen_q;
  assign cm_lut_waddr   = lut_waddr_q;
  assign cm_lut_wdata   = lut_wdata_q;
  assign cm_idata       = idata_q;
  assign cm_idata_valid = idata_valid_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    row_len_d     = row_len_q;
    lut_loaded_d  = lut_loaded_q;
    wcnt_d        = wcnt_q;
    lut_wen_d     = 1'b0;
    lut_waddr_d   = lut_waddr_q;
    lut_wdata_d   = lut_wdata_q;
    idata_d       = idata_q;
    idata_valid_d = 1'b0;
    ocnt_d        = ocnt_q;
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d      = rd_ptr_q + (PW+1)'(pop);

    if (pop) ocnt_d = m_last ? '0 : ocnt_q + LEN_ONE;

    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (accept) begin
      idata_d       = s_data;
      idata_valid_d = 1'b1;
    end

    case (state_q)
      IDLE, RUN: begin
        if (lut_load_req) begin
          shift_d      = cfg_shift;
          row_len_d    = (cfg_row_len == '0) ? LEN_ONE : cfg_row_len;
          lut_loaded_d = 1'b0;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_q == '0) begin
          state_d = LOAD;
          wcnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      LOAD: begin
        if (lut_acc) begin
          lut_wen_d   = 1'b1;
          lut_waddr_d = wcnt_q;
          lut_wdata_d = lut_in_data;
          wcnt_d      = wcnt_q + 1'b1;
          if (wcnt_q == '1) begin
            lut_loaded_d = 1'b1;
            state_d      = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      row_len_q     <= LEN_ONE;
      lut_loaded_q  <= 1'b0;
      wcnt_q        <= '0;
      lut_wen_q     <= 1'b0;
      lut_waddr_q   <= '0;
      lut_wdata_q   <= '0;
      idata_q       <= '0;
      idata_valid_q <= 1'b0;
      occ_q         <= '0;
      ocnt_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      row_len_q     <= row_len_d;
      lut_loaded_q  <= lut_loaded_d;
      wcnt_q        <= wcnt_d;
      lut_wen_q     <= lut_wen_d;
      lut_waddr_q   <= lut_waddr_d;
      lut_wdata_q   <= lut_wdata_d;
      idata_q       <= idata_d;
      idata_valid_q <= idata_valid_d;
      occ_q         <= occ_d;
      ocnt_q        <= ocnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= cm_odata;
  end

endmodule
